// File: rtl/spu_decode.sv
// SPU decode stage: buffers RI16 instruction words in a small FIFO and issues
// registered, decoded micro-ops to the execute pipes over a valid/ready handshake.

package defines_pkg;
  localparam int NUM_PIPES = 2;

  typedef enum logic [10:0] {
    IMMEDIATE_LOAD_HALFWORD       = 11'b00010000011,
    IMMEDIATE_LOAD_HALFWORD_UPPER = 11'b00010000010
  } Opcodes;
endpackage

module spu_decode #(
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_PIPES  = defines_pkg::NUM_PIPES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_inst,
  input  logic [31:0]                  in_pc,
  input  logic                         flush,
  output logic                         dec_valid,
  input  logic                         dec_ready,
  output logic [10:0]                  dec_opcode,
  output logic [6:0]                   dec_rt,
  output logic [31:0]                  dec_imm,
  output logic [$clog2(NUM_PIPES)-1:0] dec_pipe,
  output logic                         dec_illegal,
  output logic [31:0]                  dec_pc
);
  import defines_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_PIPES);

  logic [31:0]   inst_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          accept, load, pop, bypass, push, src_valid;
  logic [31:0]   src_inst, src_pc;
  logic [10:0]   nxt_opcode;
  logic [15:0]   i16;
  logic [31:0]   nxt_imm;
  logic          nxt_illegal;
  logic [PW-1:0] nxt_pipe;

  assign in_ready = (count != CW'(FIFO_DEPTH));

  always_comb begin
    accept    = in_valid && in_ready;
    load      = !dec_valid || dec_ready;
    pop       = load && (count != '0);
    // Bypass only when nothing is buffered, so program order is never violated.
    bypass    = load && (count == '0) && accept;
    push      = accept && !bypass;
    src_valid = pop || bypass;
    src_inst  = pop ? inst_mem[rd_ptr] : in_inst;
    src_pc    = pop ? pc_mem[rd_ptr]   : in_pc;

    nxt_opcode  = {2'b00, src_inst[31:23]};
    i16         = src_inst[22:7];
    nxt_imm     = '0;
    nxt_illegal = 1'b1;
    nxt_pipe    = '0;
    case (nxt_opcode)
      IMMEDIATE_LOAD_HALFWORD: begin
        nxt_imm     = {i16, i16};
        nxt_illegal = 1'b0;
      end
      IMMEDIATE_LOAD_HALFWORD_UPPER: begin
        nxt_imm     = {i16, 16'h0000};
        nxt_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      dec_valid   <= 1'b0;
      dec_opcode  <= '0;
      dec_rt      <= '0;
      dec_imm     <= '0;
      dec_pipe    <= '0;
      dec_illegal <= 1'b0;
      dec_pc      <= '0;
    end else if (flush) begin
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      dec_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (load) begin
        dec_valid   <= src_valid;
        dec_opcode  <= src_valid ? nxt_opcode     : '0;
        dec_rt      <= src_valid ? src_inst[6:0]  : '0;
        dec_imm     <= src_valid ? nxt_imm        : '0;
        dec_pipe    <= src_valid ? nxt_pipe       : '0;
        dec_illegal <= src_valid ? nxt_illegal    : 1'b0;
        dec_pc      <= src_valid ? src_pc         : '0;
      end
    end
  end

endmodule
